// File: rtl/ruleid_mem_arbiter_pkg.sv
// Shared types and default geometry for the rule-ID table RAM arbiter.
package ruleid_mem_arbiter_pkg;
    localparam int RULEID_AWIDTH = 9;
    localparam int RULEID_DWIDTH = 512;

    typedef enum logic {LOAD, RUN} ld_state_t;
endpackage

// File: rtl/ruleid_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from rr_ptr upward.
module rr_arbiter #(
    parameter int NUM_RD = 4,
    parameter int PW     = $clog2(NUM_RD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_RD-1:0] req,
    output logic [NUM_RD-1:0] gnt
);
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] cand;
    logic [PW-1:0] gnt_idx;
    logic          found;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_RD) s = s - NUM_RD;
        return PW'(s);
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= wrap_add(gnt_idx, 1);
        end
    end
endmodule

// File: rtl/ruleid_mem_arbiter.sv
// Single-port owner of the rule-ID table RAM: sequential table load from the rule
// stream, with round-robin lookup reads filling the remaining cycles.
module ruleid_mem_arbiter
    import ruleid_mem_arbiter_pkg::*;
#(
    parameter int NUM_RD   = 4,
    parameter int AWIDTH   = RULEID_AWIDTH,
    parameter int DWIDTH   = RULEID_DWIDTH,
    parameter int RD_LAT   = 2,
    parameter int WR_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DWIDTH-1:0]        load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic                     clear,
    output logic                     load_done,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*AWIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_gnt,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [DWIDTH-1:0]        rd_data,
    output logic [AWIDTH-1:0]        mem_addr,
    output logic                     mem_wren,
    output logic                     mem_rden,
    output logic [DWIDTH-1:0]        mem_wdata,
    input  logic [DWIDTH-1:0]        mem_q
);
    localparam int              BW        = $clog2(WR_BURST + 1);
    localparam logic [AWIDTH-1:0] LAST_ADDR = '1;
    localparam logic [BW-1:0]   BURST_MAX = BW'(WR_BURST);

    ld_state_t                   state;
    logic [AWIDTH-1:0]           wr_ptr;
    logic [BW-1:0]               burst_cnt;
    logic                        wr_acc;
    logic                        rd_any;
    logic [AWIDTH-1:0]           rd_addr_sel;
    logic [RD_LAT:0][NUM_RD-1:0] ret_gnt_p;

    // A pending lookup steals one slot once the write burst has run its full length.
    assign wr_acc     = (state == LOAD) && load_valid && !clear &&
                        !((burst_cnt == BURST_MAX) && (|rd_req));
    assign load_ready = wr_acc;
    assign load_done  = (state == RUN);
    assign rd_any     = |rd_gnt;

    rr_arbiter #(.NUM_RD(NUM_RD)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!wr_acc),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    always_comb begin
        rd_addr_sel = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_gnt[i]) rd_addr_sel = rd_addr[i*AWIDTH +: AWIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            wr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            if (clear) begin
                state  <= LOAD;
                wr_ptr <= '0;
            end else if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == LAST_ADDR) state <= RUN;
            end
            if (state == RUN || rd_any) begin
                burst_cnt <= '0;
            end else if (wr_acc && burst_cnt != BURST_MAX) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wren  <= 1'b0;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ret_gnt_p <= '0;
            rd_valid  <= '0;
            rd_data   <= '0;
        end else begin
            // p0: RAM port command registers
            mem_wren <= wr_acc;
            mem_rden <= rd_any;
            if (wr_acc) begin
                mem_addr  <= wr_ptr;
                mem_wdata <= load_data;
            end else if (rd_any) begin
                mem_addr <= rd_addr_sel;
            end
            // p0..pRD_LAT: grant tag follows the read through the RAM latency
            ret_gnt_p <= {ret_gnt_p[RD_LAT-1:0], rd_gnt};
            // return: capture mem_q for the tagged requester
            rd_valid <= ret_gnt_p[RD_LAT];
            if (|ret_gnt_p[RD_LAT]) rd_data <= mem_q;
        end
    end
endmodule

// File: tb/tb_ruleid_mem_arbiter.sv
// Scoreboard bench for ruleid_mem_arbiter with a behavioural RAM model.
module tb_ruleid_mem_arbiter;
    localparam int NUM_RD   = 4;
    localparam int AWIDTH   = 9;
    localparam int DWIDTH   = 512;
    localparam int RD_LAT   = 2;
    localparam int WR_BURST = 8;
    localparam int DEPTH    = 512;

    typedef struct { logic [AWIDTH-1:0] addr; logic [DWIDTH-1:0] data; int cyc; } wr_exp_t;
    typedef struct { logic [NUM_RD-1:0] who;  logic [DWIDTH-1:0] data; int cyc; } rd_exp_t;

    logic                     clk;
    logic                     rst_n;
    logic [DWIDTH-1:0]        load_data;
    logic                     load_valid;
    logic                     load_ready;
    logic                     clear;
    logic                     load_done;
    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*AWIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_gnt;
    logic [NUM_RD-1:0]        rd_valid;
    logic [DWIDTH-1:0]        rd_data;
    logic [AWIDTH-1:0]        mem_addr;
    logic                     mem_wren;
    logic                     mem_rden;
    logic [DWIDTH-1:0]        mem_wdata;
    logic [DWIDTH-1:0]        mem_q;

    logic [AWIDTH-1:0] addr_m [NUM_RD];
    logic [DWIDTH-1:0] ram    [DEPTH];
    logic [DWIDTH-1:0] shadow [DEPTH];
    logic [DWIDTH-1:0] q_p1;

    wr_exp_t wq[$];
    rd_exp_t rq[$];
    wr_exp_t mon_w;
    rd_exp_t mon_r;
    int      dut_gnt_log[$];

    int   n_vec, n_miscmp;
    int   cyc;
    int   wr_ptr_m, burst_m, rr_m, ld_idx, salt;
    int   dut_acc, wr_seen, rv_seen;
    logic done_m;

    assign rd_addr = {addr_m[3], addr_m[2], addr_m[1], addr_m[0]};

    ruleid_mem_arbiter #(
        .NUM_RD(NUM_RD), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .RD_LAT(RD_LAT), .WR_BURST(WR_BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .clear      (clear),
        .load_done  (load_done),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .mem_addr   (mem_addr),
        .mem_wren   (mem_wren),
        .mem_rden   (mem_rden),
        .mem_wdata  (mem_wdata),
        .mem_q      (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with RD_LAT=2: rden cycle c -> mem_q valid during c+2
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        if (mem_rden) q_p1 <= ram[mem_addr];
        mem_q <= q_p1;
    end

    function automatic logic [DWIDTH-1:0] line_of(input int a, input int s);
        logic [31:0] w;
        w = 32'(a) * 32'h9E3779B1 + 32'(s) * 32'h01000193 + 32'h5A5A0000;
        return {8{w, ~w}};
    endfunction

    task automatic chk(input string tag, input logic [DWIDTH-1:0] got, input logic [DWIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string ph);
        chk({ph, "_load_ready"}, 512'(load_ready), '0);
        chk({ph, "_load_done"},  512'(load_done),  '0);
        chk({ph, "_rd_gnt"},     512'(rd_gnt),     '0);
        chk({ph, "_rd_valid"},   512'(rd_valid),   '0);
        chk({ph, "_rd_data"},    rd_data,          '0);
        chk({ph, "_mem_addr"},   512'(mem_addr),   '0);
        chk({ph, "_mem_wren"},   512'(mem_wren),   '0);
        chk({ph, "_mem_rden"},   512'(mem_rden),   '0);
        chk({ph, "_mem_wdata"},  mem_wdata,        '0);
    endtask

    task automatic reset_model();
        wr_ptr_m = 0;
        burst_m  = 0;
        rr_m     = 0;
        done_m   = 1'b0;
    endtask

    // One clock: check comb outputs against the model at negedge, predict, then advance.
    task automatic step();
        logic [NUM_RD-1:0] eg;
        logic              exp_lr, done_nx;
        int                idx;
        @(negedge clk);
        exp_lr = !done_m && load_valid && !clear && !((burst_m == WR_BURST) && (rd_req != '0));
        eg  = '0;
        idx = 0;
        if (!exp_lr && rd_req != '0) begin
            idx = rr_m;
            while (!rd_req[2'(idx)]) idx = (idx + 1) % NUM_RD;
            eg[2'(idx)] = 1'b1;
        end
        chk("load_ready", 512'(load_ready), 512'(exp_lr));
        chk("rd_gnt",     512'(rd_gnt),     512'(eg));
        chk("load_done",  512'(load_done),  512'(done_m));
        if (load_ready) dut_acc++;
        for (int i = 0; i < NUM_RD; i++) if (rd_gnt[2'(i)]) dut_gnt_log.push_back(i);
        done_nx = done_m;
        if (exp_lr) begin
            wq.push_back('{addr: AWIDTH'(wr_ptr_m), data: load_data, cyc: cyc + 1});
            shadow[AWIDTH'(wr_ptr_m)] = load_data;
            if (wr_ptr_m == DEPTH - 1) done_nx = 1'b1;
            wr_ptr_m++;
            if (burst_m < WR_BURST) burst_m++;
        end
        if (eg != '0) begin
            rq.push_back('{who: eg, data: shadow[addr_m[idx]], cyc: cyc + RD_LAT + 2});
            rr_m    = (idx + 1) % NUM_RD;
            burst_m = 0;
        end
        if (done_m) burst_m = 0;
        if (clear) begin
            wr_ptr_m = 0;
            done_nx  = 1'b0;
        end
        @(posedge clk);
        done_m = done_nx;
        #1;
        rd_req = rd_req & ~eg;
        clear  = 1'b0;
        if (exp_lr) begin
            ld_idx++;
            load_data = line_of(ld_idx, salt);
        end
    endtask

    task automatic start_load(input int s);
        salt       = s;
        ld_idx     = 0;
        load_data  = line_of(0, s);
        load_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("one_op", 512'(mem_wren & mem_rden), '0);
            if (mem_wren) begin
                wr_seen++;
                if (wq.size() == 0) begin
                    chk("wr_spurious", 512'(mem_wren), '0);
                end else begin
                    mon_w = wq.pop_front();
                    chk("wr_addr", 512'(mem_addr), 512'(mon_w.addr));
                    chk("wr_data", mem_wdata, mon_w.data);
                    chk("wr_cyc",  512'(cyc), 512'(mon_w.cyc));
                end
            end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
                mon_w = wq.pop_front();
                chk("wr_missing", 512'(mem_wren), 512'(1'b1));
            end
            if (rd_valid != '0) begin
                rv_seen++;
                if (rq.size() == 0) begin
                    chk("rd_spurious", 512'(rd_valid), '0);
                end else begin
                    mon_r = rq.pop_front();
                    chk("rd_valid", 512'(rd_valid), 512'(mon_r.who));
                    chk("rd_data",  rd_data, mon_r.data);
                    chk("rd_cyc",   512'(cyc), 512'(mon_r.cyc));
                end
            end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
                mon_r = rq.pop_front();
                chk("rd_missing", 512'(rd_valid), 512'(mon_r.who));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, rv0;
        n_vec = 0; n_miscmp = 0;
        dut_acc = 0; wr_seen = 0; rv_seen = 0;
        rst_n = 1'b0; clear = 1'b0; load_valid = 1'b0; rd_req = '0;
        salt = 0; ld_idx = 0; load_data = '0;
        for (int i = 0; i < NUM_RD; i++) addr_m[i] = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        reset_model();

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // full table load, no lookups
        start_load(1);
        for (int n = 0; n < 1200 && load_done !== 1'b1; n++) step();
        chk("load1_done", 512'(load_done), 512'(1'b1));
        step();
        load_valid = 1'b0;
        repeat (2) step();
        chk("load1_wr_count", 512'(wr_seen), 512'(DEPTH));

        // four lookups granted in round-robin order
        addr_m[0] = 9'd3; addr_m[1] = 9'd7; addr_m[2] = 9'd11; addr_m[3] = 9'd15;
        rd_req = 4'b1111;
        dut_gnt_log.delete();
        for (int n = 0; n < 20 && rd_req != '0; n++) step();
        chk("rr_count", 512'(dut_gnt_log.size()), 512'(4));
        for (int i = 0; i < dut_gnt_log.size() && i < 4; i++) chk("rr_order", 512'(dut_gnt_log[i]), 512'(i));
        repeat (6) step();

        // write burst interrupted by one read to requester 2
        clear = 1'b1;
        step();
        start_load(2);
        addr_m[2] = 9'd20;
        rd_req    = 4'b0100;
        dut_gnt_log.delete();
        a0 = dut_acc;
        for (int n = 0; n < 40 && rd_req != '0; n++) step();
        chk("burst_len", 512'(dut_acc - a0), 512'(WR_BURST));
        chk("burst_gnt_n", 512'(dut_gnt_log.size()), 512'(1));
        if (dut_gnt_log.size() > 0) chk("burst_gnt_idx", 512'(dut_gnt_log[0]), 512'(2));
        a0 = dut_acc;
        step();
        chk("burst_resume", 512'(dut_acc - a0), 512'(1));

        // clear collides with a write at wr_ptr=100
        for (int n = 0; n < 200 && wr_ptr_m != 100; n++) step();
        clear = 1'b1;
        step();
        chk("clr_no_wren", 512'(mem_wren), '0);
        for (int n = 0; n < 1200 && load_done !== 1'b1; n++) step();
        chk("load2_done", 512'(load_done), 512'(1'b1));
        load_valid = 1'b0;
        repeat (2) step();

        // clear in RUN with two lookups in flight
        addr_m[0] = 9'd30; addr_m[1] = 9'd40;
        rd_req = 4'b0011;
        rv0 = rv_seen;
        step();
        step();
        clear = 1'b1;
        step();
        repeat (6) step();
        chk("clr_inflight_rv", 512'(rv_seen - rv0), 512'(2));
        chk("clr_load_done", 512'(load_done), '0);
        start_load(4);
        repeat (12) step();
        load_valid = 1'b0;
        repeat (2) step();

        // async reset with lookups in flight
        addr_m[0] = 9'd2; addr_m[1] = 9'd5;
        rd_req = 4'b0001;
        step();
        rd_req = 4'b0010;
        step();
        rd_req = '0;
        rst_n  = 1'b0;
        #1;
        check_zero("midrst");
        wq.delete();
        rq.delete();
        rv0 = rv_seen;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        repeat (6) step();
        chk("rst_drop_rv", 512'(rv_seen - rv0), '0);
        start_load(5);
        repeat (3) step();
        load_valid = 1'b0;
        repeat (4) step();

        chk("wq_drained", 512'(wq.size()), '0);
        chk("rq_drained", 512'(rq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
